// File: rtl/screen_pkg.sv
// Shared raster geometry for the 160x120 VGA screen, plus the plot-driver state encoding.
// Pure declarations: no latency and no backpressure.
package screen_pkg;

    localparam int SCREEN_W      = 160;
    localparam int SCREEN_H      = 120;
    localparam int SCREEN_PIXELS = 19200;
    localparam int SCREEN_ADDR_W = 15;
    localparam int X_W           = 8;
    localparam int Y_W           = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } plot_state_t;

    // Travels alongside a ROM access so the returned word can be placed on screen.
    typedef struct packed {
        logic           vld;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pix_tag_t;

endpackage

// File: rtl/screen_plot_driver_if.sv
// Bundles the plot driver's control handshake, ROM read port and VGA pixel-write port.
// Wires only: no latency and no backpressure.
interface screen_plot_driver_if #(
    parameter int COLOUR_BITS = 3
);
    import screen_pkg::*;

    logic                     start;
    logic                     busy;
    logic                     done;
    logic [SCREEN_ADDR_W-1:0] rom_addr;
    logic [COLOUR_BITS-1:0]   rom_data;
    logic [X_W-1:0]           x;
    logic [Y_W-1:0]           y;
    logic [COLOUR_BITS-1:0]   colour;
    logic                     plot;

    modport master (
        input  start, rom_data,
        output busy, done, rom_addr, x, y, colour, plot
    );

    modport slave (
        output start, rom_data,
        input  busy, done, rom_addr, x, y, colour, plot
    );

endinterface

// File: rtl/screen_xy_counter.sv
// Row-major raster counter giving x, y and the matching linear address; saturates on the last pixel.
// Outputs are registers updated one edge after clr/en; no backpressure beyond en.
module screen_xy_counter
    import screen_pkg::*;
(
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     clr,
    input  logic                     en,
    output logic [X_W-1:0]           x,
    output logic [Y_W-1:0]           y,
    output logic [SCREEN_ADDR_W-1:0] addr,
    output logic                     last
);

    assign last = (x == X_W'(SCREEN_W - 1)) && (y == Y_W'(SCREEN_H - 1));

    // The linear address is kept as its own incrementer so no y*160 multiply is needed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (clr) begin
            x    <= '0;
            y    <= '0;
            addr <= '0;
        end else if (en && !last) begin
            addr <= addr + SCREEN_ADDR_W'(1);
            if (x == X_W'(SCREEN_W - 1)) begin
                x <= '0;
                y <= y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/screen_plot_driver.sv
// Replays a full 160x120 ROM image into the VGA write port, one pixel per clock once started.
// First plot ROM_LATENCY+1 cycles after the first address; no backpressure, start ignored while busy.
module screen_plot_driver
    import screen_pkg::*;
#(
    parameter int COLOUR_BITS = 3,
    parameter int ROM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    screen_plot_driver_if.master bus
);

    plot_state_t              state;
    plot_state_t              state_nxt;
    logic                     cnt_clr;
    logic                     cnt_en;
    logic [X_W-1:0]           cnt_x;
    logic [Y_W-1:0]           cnt_y;
    logic [SCREEN_ADDR_W-1:0] cnt_addr;
    logic                     cnt_last;
    logic [2:0]               drain_cnt;
    pix_tag_t                 tag_in;
    pix_tag_t                 pipe [ROM_LATENCY];

    logic                     busy_q;
    logic                     done_q;
    logic [X_W-1:0]           x_q;
    logic [Y_W-1:0]           y_q;
    logic [COLOUR_BITS-1:0]   colour_q;
    logic                     plot_q;

    screen_xy_counter u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .x      (cnt_x),
        .y      (cnt_y),
        .addr   (cnt_addr),
        .last   (cnt_last)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_ISSUE;
                    cnt_clr   = 1'b1;
                end
            end
            ST_ISSUE: begin
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_nxt = ST_DRAIN;
                end
            end
            // Stay until the last ROM word has been registered onto the pixel port.
            ST_DRAIN: begin
                if (drain_cnt == 3'(ROM_LATENCY)) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drain_cnt <= '0;
        end else if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + 3'(1);
        end else begin
            drain_cnt <= '0;
        end
    end

    assign tag_in = '{vld: (state == ST_ISSUE), x: cnt_x, y: cnt_y};

    // Last stage lines up with rom_data for the address issued ROM_LATENCY cycles earlier.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            x_q      <= pipe[ROM_LATENCY-1].x;
            y_q      <= pipe[ROM_LATENCY-1].y;
            colour_q <= bus.rom_data;
            plot_q   <= pipe[ROM_LATENCY-1].vld;
            busy_q   <= (state_nxt == ST_ISSUE) || (state_nxt == ST_DRAIN);
            done_q   <= (state_nxt == ST_DONE);
        end
    end

    assign bus.rom_addr = cnt_addr;
    assign bus.x        = x_q;
    assign bus.y        = y_q;
    assign bus.colour   = colour_q;
    assign bus.plot     = plot_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_screen_plot_driver.sv
// Drives two plot drivers (ROM latency 1 and 3) against ROM models whose word is addr[2:0].
// Stimulus pushes expected pixels/done/first-cycle into queues; one negedge monitor pops and compares.
module tb_screen_plot_driver;

    typedef struct {
        int at;
        int x;
        int y;
        int c;
    } pix_exp_t;

    logic clk;
    logic resetn;
    logic start_s [2];
    int   edge_cnt = 0;

    pix_exp_t pq [2][$];
    int       dq [2][$];
    int       cq [2][$];

    int   checks = 0;
    int   errors = 0;
    logic end_req = 1'b0;
    logic end_done = 1'b0;
    logic pbusy [2];

    logic       pl [2];
    logic       dn [2];
    logic       bz [2];
    logic [7:0] xs [2];
    logic [6:0] ys [2];
    logic [2:0] cs [2];
    logic [14:0] ra [2];

    logic [2:0] rom0;
    logic [2:0] rom1_a, rom1_b, rom1_c;

    screen_plot_driver_if #(.COLOUR_BITS(3)) bus0 ();
    screen_plot_driver_if #(.COLOUR_BITS(3)) bus1 ();

    screen_plot_driver #(.COLOUR_BITS(3), .ROM_LATENCY(1)) dut_l1 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus0)
    );

    screen_plot_driver #(.COLOUR_BITS(3), .ROM_LATENCY(3)) dut_l3 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus1)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        rom0   <= bus0.rom_addr[2:0];
        rom1_a <= bus1.rom_addr[2:0];
        rom1_b <= rom1_a;
        rom1_c <= rom1_b;
    end

    assign bus0.rom_data = rom0;
    assign bus1.rom_data = rom1_c;
    assign bus0.start    = start_s[0];
    assign bus1.start    = start_s[1];

    assign pl[0] = bus0.plot;     assign pl[1] = bus1.plot;
    assign dn[0] = bus0.done;     assign dn[1] = bus1.done;
    assign bz[0] = bus0.busy;     assign bz[1] = bus1.busy;
    assign xs[0] = bus0.x;        assign xs[1] = bus1.x;
    assign ys[0] = bus0.y;        assign ys[1] = bus1.y;
    assign cs[0] = bus0.colour;   assign cs[1] = bus1.colour;
    assign ra[0] = bus0.rom_addr; assign ra[1] = bus1.rom_addr;

    // Called #1 after the edge that accepted start; edge_cnt then identifies cycle 1.
    task automatic push_frame(input int ln);
        int n0;
        int lat;
        n0  = edge_cnt;
        lat = (ln == 0) ? 1 : 3;
        cq[ln].push_back(n0);
        for (int k = 0; k < 19200; k++) begin
            pq[ln].push_back('{n0 + k + 1 + lat, k % 160, k / 160, k % 8});
        end
        dq[ln].push_back(n0 + 19201 + lat);
    endtask

    task automatic wait_done(input int ln);
        for (int i = 0; i < 25000; i++) begin
            @(negedge clk);
            if (dn[ln]) break;
        end
    endtask

    // Start held high across a whole frame, its drain and done, so the frame after starts
    // on the first idle edge following done.
    task automatic lane_run(input int ln);
        @(negedge clk);
        start_s[ln] = 1'b1;
        @(posedge clk);
        #1 push_frame(ln);
        wait_done(ln);
        @(posedge clk);
        @(posedge clk);
        #1 push_frame(ln);
        start_s[ln] = 1'b0;
        wait_done(ln);
        repeat (3) @(posedge clk);
    endtask

    always @(negedge clk) begin
        pix_exp_t e;
        int d;
        int c1;
        for (int ln = 0; ln < 2; ln++) begin
            if (!resetn) begin
                checks++;
                if (pl[ln] || dn[ln] || bz[ln] || ra[ln] != 0 || xs[ln] != 0 || ys[ln] != 0 || cs[ln] != 0) begin
                    errors++;
                    $display("FAIL reset_outputs lane%0d got plot=%0b done=%0b busy=%0b addr=%0d x=%0d y=%0d c=%0d, want all 0",
                             ln, pl[ln], dn[ln], bz[ln], ra[ln], xs[ln], ys[ln], cs[ln]);
                end
            end else begin
                checks++;
                if (ra[ln] > 15'd19199) begin
                    errors++;
                    $display("FAIL rom_addr_range lane%0d got %0d, want <= 19199", ln, ra[ln]);
                end
                if (cq[ln].size() > 0 && edge_cnt == cq[ln][0]) begin
                    c1 = cq[ln].pop_front();
                    checks++;
                    if (ra[ln] != 0 || !bz[ln] || pl[ln]) begin
                        errors++;
                        $display("FAIL first_cycle lane%0d edge %0d got addr=%0d busy=%0b plot=%0b, want addr=0 busy=1 plot=0",
                                 ln, c1, ra[ln], bz[ln], pl[ln]);
                    end
                end
                if (pl[ln]) begin
                    checks++;
                    if (pq[ln].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_plot lane%0d at edge %0d got x=%0d y=%0d, want no plot",
                                 ln, edge_cnt, xs[ln], ys[ln]);
                    end else begin
                        e = pq[ln].pop_front();
                        if (edge_cnt != e.at || int'(xs[ln]) != e.x || int'(ys[ln]) != e.y
                            || int'(cs[ln]) != e.c || !bz[ln]) begin
                            errors++;
                            $display("FAIL pixel lane%0d got edge=%0d x=%0d y=%0d c=%0d busy=%0b, want edge=%0d x=%0d y=%0d c=%0d busy=1",
                                     ln, edge_cnt, xs[ln], ys[ln], cs[ln], bz[ln], e.at, e.x, e.y, e.c);
                        end
                    end
                end
                if (dn[ln]) begin
                    checks++;
                    if (dq[ln].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done lane%0d at edge %0d, want no done", ln, edge_cnt);
                    end else begin
                        d = dq[ln].pop_front();
                        if (edge_cnt != d || bz[ln] || !pbusy[ln]) begin
                            errors++;
                            $display("FAIL done_timing lane%0d got edge=%0d busy=%0b prev_busy=%0b, want edge=%0d busy=0 prev_busy=1",
                                     ln, edge_cnt, bz[ln], pbusy[ln], d);
                        end
                    end
                end
            end
            pbusy[ln] = bz[ln];
        end
        if (end_req && !end_done) begin
            for (int ln = 0; ln < 2; ln++) begin
                checks++;
                if (pq[ln].size() != 0 || dq[ln].size() != 0 || cq[ln].size() != 0) begin
                    errors++;
                    $display("FAIL leftover lane%0d got pixels=%0d dones=%0d firsts=%0d outstanding, want 0",
                             ln, pq[ln].size(), dq[ln].size(), cq[ln].size());
                end
            end
            end_done = 1'b1;
        end
    end

    initial begin
        resetn     = 1'b0;
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (2) @(posedge clk);

        // Frame aborted by reset part-way through; no pixels or done may follow.
        @(negedge clk);
        start_s[0] = 1'b1;
        start_s[1] = 1'b1;
        @(posedge clk);
        #1 push_frame(0);
        push_frame(1);
        start_s[0] = 1'b0;
        start_s[1] = 1'b0;
        repeat (5000) @(posedge clk);
        #2 resetn = 1'b0;
        for (int ln = 0; ln < 2; ln++) begin
            pq[ln].delete();
            dq[ln].delete();
            cq[ln].delete();
        end
        repeat (3) @(posedge clk);
        #2 resetn = 1'b1;
        repeat (3) @(posedge clk);

        fork
            lane_run(0);
            lane_run(1);
        join

        end_req = 1'b1;
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
